// File: rtl/cpu_types_pkg.sv
// Shared types for the memory bus arbiter: RAM handshake states, the
// arbiter FSM encoding and the registered grant record.
package cpu_types_pkg;
    localparam int WORD_W  = 32;
    localparam int CPUID_W = 4;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [CPUID_W-1:0] cpuid;
        logic               is_data;
        logic               is_write;
        word_t              addr;
        word_t              store;
    } grant_t;
endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: scans cores upward from rr (mod CPUS)
// and returns the first one with a pending request.
module rr_pick
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2,
    parameter int CW   = (CPUS > 1) ? $clog2(CPUS) : 1
) (
    input  logic [CPUS-1:0] req,
    input  logic [CW-1:0]   rr,
    output logic [CW-1:0]   winner,
    output logic            valid
);
    function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] base, input int ofs);
        int k;
        k = int'(base) + ofs;
        if (k >= CPUS) k = k - CPUS;
        return CW'(k);
    endfunction

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < CPUS; i++) begin
            if (!valid && req[wrap_idx(rr, i)]) begin
                winner = wrap_idx(rr, i);
                valid  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises per-core I/D cache requests onto the single shared RAM port;
// the granted port sees wait low for exactly the RAM ACCESS cycle.
module mem_bus_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS-1:0][AW-1:0]  iaddr,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS-1:0][AW-1:0]  daddr,
    input  logic [CPUS-1:0][DW-1:0]  dstore,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS-1:0][DW-1:0]  iload,
    output logic [CPUS-1:0][DW-1:0]  dload,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [AW-1:0]            ramaddr,
    output logic [DW-1:0]            ramstore,
    input  logic [DW-1:0]            ramload,
    input  logic [1:0]               ramstate
);
    localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;

    arb_state_t      state_q, state_d;
    grant_t          grant_q, grant_d;
    logic [CW-1:0]   rr_q, rr_d;
    logic [CPUS-1:0] req, gsel, gline;
    logic [CW-1:0]   win;
    logic            win_vld, held;

    assign req = iREN | dREN | dWEN;

    rr_pick #(.CPUS(CPUS), .CW(CW)) u_pick (
        .req    (req),
        .rr     (rr_q),
        .winner (win),
        .valid  (win_vld)
    );

    // One-hot of the granted core and the request line that must stay high;
    // a drop on that line is an abort.
    always_comb begin
        gsel = '0;
        for (int c = 0; c < CPUS; c++) gsel[c] = (grant_q.cpuid == CPUID_W'(c));
        gline = grant_q.is_data ? (grant_q.is_write ? dWEN : dREN) : iREN;
        held  = |(gsel & gline);
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    grant_d.cpuid    = CPUID_W'(win);
                    grant_d.is_data  = dREN[win] | dWEN[win];
                    grant_d.is_write = dWEN[win];
                    grant_d.addr     = (dREN[win] | dWEN[win]) ? daddr[win] : iaddr[win];
                    grant_d.store    = dWEN[win] ? dstore[win] : '0;
                    state_d          = GRANT;
                end
            end
            GRANT: begin
                ramREN   = !grant_q.is_write;
                ramWEN   = grant_q.is_write;
                ramaddr  = grant_q.addr;
                ramstore = grant_q.store;
                if (!held) begin
                    state_d = IDLE;
                end else if (ramstate_t'(ramstate) == ACCESS) begin
                    for (int c = 0; c < CPUS; c++) begin
                        if (gsel[c]) begin
                            if (grant_q.is_data) begin
                                dwait[c] = 1'b0;
                                dload[c] = grant_q.is_write ? '0 : ramload;
                            end else begin
                                iwait[c] = 1'b0;
                                iload[c] = ramload;
                            end
                        end
                    end
                    state_d = IDLE;
                    rr_d    = (int'(grant_q.cpuid) >= CPUS - 1) ? '0 : CW'(grant_q.cpuid + 1'b1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Downstream neighbour of the per-core instruction and data caches.
- Accepts word-granular read/write requests from CPUS cores (one I-port and one D-port each) and serialises them onto the single shared RAM port.
- Returns per-port wait/load: wait low for exactly one cycle marks completion.
- Caches see it as the ccif side: iREN/dREN/dWEN/addr/store in; iwait/dwait/iload/dload out.

Parameters:
- CPUS, 2, number of cores; ports indexed 0..CPUS-1.
- AW, 32, address width; word-aligned, addr[1:0] ignored.
- DW, 32, data word width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  CPUS  instruction read request per core.
- iaddr  in  CPUS x AW  instruction address.
- dREN  in  CPUS  data read request.
- dWEN  in  CPUS  data write request.
- daddr  in  CPUS x AW  data address.
- dstore  in  CPUS x DW  data write value.
- iwait  out  CPUS  1 = instruction request not complete.
- dwait  out  CPUS  1 = data request not complete.
- iload  out  CPUS x DW  instruction read data, valid when iwait low.
- dload  out  CPUS x DW  data read data, valid when dwait low.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  AW  RAM address.
- ramstore  out  DW  RAM write data.
- ramload  in  DW  RAM read data.
- ramstate  in  2  FREE / BUSY / ACCESS / ERROR.

Behaviour:
- Reset values:
  - all iwait/dwait = 1; iload/dload = 0.
  - ramREN = ramWEN = 0; ramaddr/ramstore = 0.
  - FSM = IDLE; round-robin pointer rr = 0.
- Requester contract: a requester holds its request and operands stable until it sees its wait low. Any deassertion before that is an abort.
- FSM states: IDLE, GRANT.
- IDLE:
  - Arbitrate combinationally and register the winner into the grant record (cpu, is_data, is_write, addr, store) at the clock edge, then go to GRANT.
  - RAM enables are 0 in IDLE.
- Arbitration order:
  - Core order: start at core rr and scan upward modulo CPUS; the first core with any request wins.
  - Within the winning core, the D-port beats the I-port.
  - dWEN beats dREN if both are asserted (treated as a write).
- GRANT:
  - Drive ramREN/ramWEN (exactly one), ramaddr and ramstore from the grant record.
  - If ramstate == ACCESS: the granted port's wait = 0 combinationally in this cycle; its load = ramload on a read, 0 on a write. Next state IDLE; rr <= (granted cpu + 1) mod CPUS.
  - If ramstate is BUSY or FREE: stay in GRANT, wait stays 1.
  - If ramstate == ERROR: stay in GRANT and re-issue the same access (retry); no wait pulse.
  - Abort: if the granted request line drops (e.g. a cache hit resolved), return to IDLE next edge. No wait pulse; RAM enables drop in that IDLE cycle; rr unchanged.
- Latency:
  - Request seen in IDLE at cycle N; RAM enable asserted in cycle N+1.
  - With a zero-wait RAM, wait goes low in cycle N+1.
  - There is a one-cycle IDLE bubble between consecutive grants, so the minimum is 2 cycles per access.
- Only the granted port ever has wait = 0; all other ports read wait = 1 and load = 0.
- Simultaneous requests from all ports: each completes exactly once; no port starves beyond CPUS grants of other cores.
- Reset mid-GRANT: immediate return to reset values; the in-flight access is discarded.
- Address passes through unmodified, full AW bits.

Decomposition:
- cpu_types_pkg holds:
  - word_t (DW), ramstate_t enum {FREE, BUSY, ACCESS, ERROR}.
  - the grant record typedef (cpuid, is_data, is_write, word_t addr, word_t store).
  - the arbiter state enum {IDLE, GRANT}.
- One sub-module, rr_pick: a combinational round-robin selector. Inputs are the per-core request vector and rr; outputs are winner index and valid. Instantiated once.

Test Plan:
- Single read: core0 dREN=1, daddr=0x100, RAM ACCESS at once with ramload=0xDEADBEEF -> cycle 1 ramREN=1, ramaddr=0x100; dwait[0]=0 and dload[0]=0xDEADBEEF for exactly one cycle.
- D over I: core0 iREN and dWEN together (daddr=0x40, dstore=0x12345678) -> first grant ramWEN=1, ramaddr=0x40, ramstore=0x12345678; the I read completes on a later grant.
- Round-robin: both cores' dREN held continuously, zero-wait RAM -> completions alternate core0, core1, core0, core1 with a one-cycle bubble between each.
- Slow RAM: ramstate BUSY for 3 cycles, then ERROR for 1, then ACCESS -> enables and address held throughout; wait low only in the ACCESS cycle.
- Abort: core1 dREN granted, dREN dropped while BUSY -> next cycle IDLE, ramREN=0, no dwait pulse, rr unchanged.
- Reset mid-GRANT: nRST asserted while BUSY -> same cycle ramREN/ramWEN=0 and all waits=1; after release the first pending request is granted from core0.
